// File: rtl/player_missile_ctrl.sv
// Player missile launcher: launches from the ship on a Fire edge, climbs once per
// frame, and emits a single-cycle hit when the missile box overlaps an enemy pixel.
module player_missile_ctrl #(
  parameter int MISSILE_W       = 2,
  parameter int MISSILE_H       = 8,
  parameter int MISSILE_SPEED   = 4,
  parameter int LAUNCH_Y        = 420,
  parameter int SHIP_W          = 32,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       Fire,
  input  logic       is_playing,
  input  logic [9:0] ShipX,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       enemy_on,
  output logic       hit,
  output logic       missile_on,
  output logic [7:0] missile_R,
  output logic [7:0] missile_G,
  output logic [7:0] missile_B,
  output logic [7:0] shots_fired,
  output logic [1:0] dbg_state,
  output logic [9:0] dbg_missile_x,
  output logic [9:0] dbg_missile_y
);

  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLY      = 2'd1,
    HIT      = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [9:0]      missile_x, missile_y;
  logic [CD_W-1:0] cooldown;
  logic            fire_q;
  logic            frame_s1, frame_s2, frame_s3;
  logic            frame_tick;
  logic            fire_rise;
  logic            collide;
  logic [10:0]     launch_x_raw;
  logic [9:0]      launch_x;
  logic [10:0]     x_hi, y_hi;
  logic            in_x, in_y;

  assign fire_rise = Fire & ~fire_q;

  // Launch X is centred on the ship and clamped so the whole missile stays on screen.
  always_comb begin
    launch_x_raw = {1'b0, ShipX} + 11'(SHIP_W / 2 - MISSILE_W / 2);
    if (launch_x_raw > 11'(640 - MISSILE_W)) launch_x = 10'(640 - MISSILE_W);
    else                                     launch_x = launch_x_raw[9:0];
  end

  // Box bounds carried in 11 bits so a missile near 1023 cannot wrap.
  always_comb begin
    x_hi = {1'b0, missile_x} + 11'(MISSILE_W);
    y_hi = {1'b0, missile_y} + 11'(MISSILE_H);
    in_x = (DrawX >= missile_x) && ({1'b0, DrawX} < x_hi);
    in_y = (DrawY >= missile_y) && ({1'b0, DrawY} < y_hi);
  end

  assign collide = missile_on & enemy_on & is_playing;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; a collision takes priority over a simultaneous frame tick.
  always_comb begin
    state_n = state;
    if (!is_playing) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:     if (fire_rise) state_n = FLY;
        FLY: begin
          if (collide)                                             state_n = HIT;
          else if (frame_tick && missile_y < 10'(MISSILE_SPEED))   state_n = IDLE;
        end
        HIT:      state_n = COOLDOWN;
        COOLDOWN: if (cooldown == '0 || (frame_tick && cooldown == CD_W'(1))) state_n = IDLE;
        default:  state_n = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    hit        = (state == HIT) && is_playing;
    missile_on = (state == FLY) && in_x && in_y;
    missile_R  = missile_on ? 8'hFF : 8'h00;
    missile_G  = missile_on ? 8'hFF : 8'h00;
    missile_B  = 8'h00;
  end

  // Edge detection and the missile datapath.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fire_q      <= 1'b0;
      frame_s1    <= 1'b0;
      frame_s2    <= 1'b0;
      frame_s3    <= 1'b0;
      frame_tick  <= 1'b0;
      missile_x   <= '0;
      missile_y   <= '0;
      cooldown    <= '0;
      shots_fired <= '0;
    end else begin
      fire_q     <= Fire;
      frame_s1   <= frame_clk;
      frame_s2   <= frame_s1;
      frame_s3   <= frame_s2;
      frame_tick <= frame_s2 & ~frame_s3;
      if (!is_playing) begin
        cooldown <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (fire_rise) begin
              missile_x <= launch_x;
              missile_y <= 10'(LAUNCH_Y);
              if (shots_fired != 8'hFF) shots_fired <= shots_fired + 8'd1;
            end
          end
          FLY: begin
            if (!collide && frame_tick && missile_y >= 10'(MISSILE_SPEED))
              missile_y <= missile_y - 10'(MISSILE_SPEED);
          end
          HIT:      cooldown <= CD_W'(COOLDOWN_FRAMES);
          COOLDOWN: if (frame_tick && cooldown != '0) cooldown <= cooldown - CD_W'(1);
          default:  ;
        endcase
      end
    end
  end

  assign dbg_state     = state;
  assign dbg_missile_x = missile_x;
  assign dbg_missile_y = missile_y;

endmodule
